// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop input synchronizer, start-glitch rejection, optional parity,
// and a show-ahead receive FIFO with sticky frame/parity/overrun error flags.
module uart_rx_fifo #(
   parameter int CLK_DIV    = 2604,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          RX,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rdy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          frm_err,
   output logic                          par_err,
   output logic                          ovr_err
);

   localparam int              BW       = $clog2(CLK_DIV);
   localparam int              AW       = $clog2(FIFO_DEPTH);
   localparam int              CW       = AW + 1;
   localparam logic [BW-1:0]   FULL_BIT = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0]   HALF_BIT = BW'(CLK_DIV / 2 - 1);
   localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic            ODD      = (PARITY_ODD != 0);
   localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_e;

   logic [1:0]           sync_q;
   logic                 rx_s;
   state_e               state_q;
   logic [BW-1:0]        baud_q;
   logic [3:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bad_q;
   logic                 baud_done;

   // Synchronizer resets to the idle-high line level so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], RX};
   end

   assign rx_s      = sync_q[1];
   assign baud_done = (baud_q == '0);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               par_bad_q <= 1'b0;
               if (!rx_s) begin
                  state_q <= S_START;
                  baud_q  <= HALF_BIT;
               end
            end
            S_START: begin
               if (baud_done) begin
                  if (rx_s) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q   <= S_DATA;
                     baud_q    <= FULL_BIT;
                     bit_cnt_q <= '0;
                  end
               end else begin
                  baud_q <= baud_q - BW'(1);
               end
            end
            S_DATA: begin
               if (baud_done) begin
                  shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                  baud_q    <= FULL_BIT;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == LAST_BIT)
                     state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  baud_q <= baud_q - BW'(1);
               end
            end
            S_PARITY: begin
               if (baud_done) begin
                  par_bad_q <= rx_s != ((^shift_q) ^ ODD);
                  baud_q    <= FULL_BIT;
                  state_q   <= S_STOP;
               end else begin
                  baud_q <= baud_q - BW'(1);
               end
            end
            S_STOP: begin
               if (baud_done) state_q <= rx_s ? S_IDLE : S_BREAK;
               else           baud_q  <= baud_q - BW'(1);
            end
            S_BREAK: begin
               if (rx_s) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   logic push, frm_set, par_set;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      push    = 1'b0;
      frm_set = 1'b0;
      par_set = 1'b0;
      if (state_q == S_STOP && baud_done) begin
         push    = rx_s && !par_bad_q;
         frm_set = !rx_s;
         par_set = par_bad_q;
      end
   end

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        cnt_q;
   logic                 empty, full, pop, wr, ovr_set;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_CNT);
   assign pop     = rd_en && !empty;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign wr      = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(wr) - CW'(pop);
      end
   end

   // NOTE: storage is not reset; cnt_q gates visibility, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= shift_q;
   end

   assign rx_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign rdy      = !empty;
   assign fifo_cnt = cnt_q;

   logic [2:0] err_q, err_d;

   // Clear first, then OR in new events so a set in the clearing cycle survives.
   always_comb begin
      err_d = err_clr ? 3'b000 : err_q;
      err_d = err_d | {ovr_set, par_set, frm_set};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 3'b000;
      else        err_q <= err_d;
   end

   assign {ovr_err, par_err, frm_err} = err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench: an 8N1 instance and an 8E1 instance, compared against a
// queue-based model of frames, FIFO contents and sticky flags.
module tb_uart_rx_fifo;

   localparam int CLK_DIV = 16;
   localparam int DEPTH   = 4;
   localparam int ACT_NONE = 0, ACT_POP = 1, ACT_CLR = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_a = 1'b1, rx_p = 1'b1;
   logic       rd_a = 1'b0, rd_p = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data_a, data_p;
   logic       rdy_a, rdy_p, frm_a, frm_p, par_a, par_p, ovr_a, ovr_p;
   logic [2:0] cnt_a, cnt_p;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .FIFO_DEPTH(DEPTH)) u_a (
      .clk(clk), .rst_n(rst_n), .RX(rx_a), .rd_en(rd_a), .err_clr(err_clr),
      .rx_data(data_a), .rdy(rdy_a), .fifo_cnt(cnt_a),
      .frm_err(frm_a), .par_err(par_a), .ovr_err(ovr_a));

   uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                  .FIFO_DEPTH(DEPTH)) u_p (
      .clk(clk), .rst_n(rst_n), .RX(rx_p), .rd_en(rd_p), .err_clr(err_clr),
      .rx_data(data_p), .rdy(rdy_p), .fifo_cnt(cnt_p),
      .frm_err(frm_p), .par_err(par_p), .ovr_err(ovr_p));

   // Reference model: index 0 = 8N1 instance, 1 = even-parity instance.
   logic [7:0] q_a[$], q_p[$];
   bit         frm_m[2], par_m[2], ovr_m[2];

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, rise_cyc = -1;
   bit rdy_prev_a = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (rdy_a && !rdy_prev_a) rise_cyc = cyc;
      rdy_prev_a = rdy_a;
   endtask

   task automatic clear_flags();
      for (int i = 0; i < 2; i++) begin
         frm_m[i] = 1'b0; par_m[i] = 1'b0; ovr_m[i] = 1'b0;
      end
   endtask

   task automatic model_push(input int dut, input logic [7:0] d);
      if (dut == 0) begin
         if (q_a.size() < DEPTH) q_a.push_back(d); else ovr_m[0] = 1'b1;
      end else begin
         if (q_p.size() < DEPTH) q_p.push_back(d); else ovr_m[1] = 1'b1;
      end
   endtask

   task automatic verify(input int dut, input string tag);
      logic [31:0] head;
      if (dut == 0) begin
         head = (q_a.size() > 0) ? 32'(q_a[0]) : 32'd0;
         check({tag, "_cnt"}, 32'(cnt_a), q_a.size());
         check({tag, "_rdy"}, 32'(rdy_a), 32'(q_a.size() > 0));
         check({tag, "_data"}, 32'(data_a), head);
         check({tag, "_frm"}, 32'(frm_a), 32'(frm_m[0]));
         check({tag, "_par"}, 32'(par_a), 32'(par_m[0]));
         check({tag, "_ovr"}, 32'(ovr_a), 32'(ovr_m[0]));
      end else begin
         head = (q_p.size() > 0) ? 32'(q_p[0]) : 32'd0;
         check({tag, "_cnt"}, 32'(cnt_p), q_p.size());
         check({tag, "_rdy"}, 32'(rdy_p), 32'(q_p.size() > 0));
         check({tag, "_data"}, 32'(data_p), head);
         check({tag, "_frm"}, 32'(frm_p), 32'(frm_m[1]));
         check({tag, "_par"}, 32'(par_p), 32'(par_m[1]));
         check({tag, "_ovr"}, 32'(ovr_p), 32'(ovr_m[1]));
      end
   endtask

   // Drives one whole frame; 'act' optionally pulses rd_en (8N1 side) or err_clr so that
   // the DUT sees it on the very edge that samples the stop bit.
   task automatic send(input int dut, input logic [7:0] data, input bit bad_par,
                       input bit bad_stop, input int act, output int t0);
      logic [10:0] bits;
      int n, s, t;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = data;
      if (dut == 1) begin
         bits[9]  = (^data) ^ bad_par;
         bits[10] = ~bad_stop;
         n = 11;
      end else begin
         bits[9] = ~bad_stop;
         n = 10;
      end
      // 2 sync edges + 1 detect edge, half a bit to mid-start, then one bit per later field.
      s  = 3 + CLK_DIV / 2 + (n - 1) * CLK_DIV;
      t  = 0;
      t0 = cyc;
      for (int b = 0; b < n; b++) begin
         for (int k = 0; k < CLK_DIV; k++) begin
            if (dut == 1) rx_p = bits[b]; else rx_a = bits[b];
            rd_a    = (act == ACT_POP) && (t == s - 1);
            err_clr = (act == ACT_CLR) && (t == s - 1);
            tick();
            t++;
         end
      end
      rd_a = 1'b0;
      err_clr = 1'b0;
      if (bad_stop) repeat (40) tick();
      rx_a = 1'b1;
      rx_p = 1'b1;
      repeat (4) tick();
      if (act == ACT_CLR) clear_flags();
      if (act == ACT_POP && q_a.size() > 0) void'(q_a.pop_front());
      if (bad_stop || (dut == 1 && bad_par)) begin
         frm_m[dut] = frm_m[dut] | bad_stop;
         par_m[dut] = par_m[dut] | ((dut == 1) && bad_par);
      end else begin
         model_push(dut, data);
      end
   endtask

   task automatic pop(input int dut);
      if (dut == 0) rd_a = 1'b1; else rd_p = 1'b1;
      tick();
      rd_a = 1'b0;
      rd_p = 1'b0;
      if (dut == 0 && q_a.size() > 0) void'(q_a.pop_front());
      if (dut == 1 && q_p.size() > 0) void'(q_p.pop_front());
   endtask

   task automatic clr_pulse();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      clear_flags();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx_a = 1'b1;
      rx_p = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      q_a.delete();
      q_p.delete();
      clear_flags();
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int t0, len, dut, npop;
      logic [7:0] d;
      bit bs, bp;

      clear_flags();
      repeat (3) tick();
      verify(0, "reset_a");
      verify(1, "reset_p");
      rst_n = 1'b1;
      repeat (3) tick();

      // Basic 8N1 frame, exact rdy latency, pop.
      rise_cyc = -1;
      send(0, 8'hA5, 1'b0, 1'b0, ACT_NONE, t0);
      check("t1_latency", rise_cyc - t0, 3 + CLK_DIV / 2 + 9 * CLK_DIV);
      verify(0, "t1_rx");
      pop(0);
      verify(0, "t1_pop");

      // Short low pulses shorter than half a bit are rejected.
      for (int i = 0; i < 4; i++) begin
         len = $urandom_range(1, 7);
         rx_a = 1'b0;
         rx_p = 1'b0;
         repeat (len) tick();
         rx_a = 1'b1;
         rx_p = 1'b1;
         repeat (30) tick();
         verify(0, "t2_glitch_a");
         verify(1, "t2_glitch_p");
      end
      pop(0);
      verify(0, "t2_pop_empty");

      // Parity error, clear racing a set, then plain clear.
      send(1, 8'h03, 1'b1, 1'b0, ACT_NONE, t0);
      verify(1, "t3_par");
      send(1, 8'h44, 1'b1, 1'b0, ACT_CLR, t0);
      verify(1, "t3_set_wins");
      clr_pulse();
      verify(1, "t3_clr");
      send(1, 8'h81, 1'b0, 1'b0, ACT_NONE, t0);
      verify(1, "t3_good");
      pop(1);

      // Framing error with long break, then recovery.
      send(0, 8'h55, 1'b0, 1'b1, ACT_NONE, t0);
      verify(0, "t4_frm");
      send(0, 8'h12, 1'b0, 1'b0, ACT_NONE, t0);
      verify(0, "t4_after");
      clr_pulse();

      // Overrun, pops in order, then full + push + pop in the same cycle.
      do_reset();
      for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b0, ACT_NONE, t0);
      verify(0, "t5_full");
      for (int i = 0; i < 4; i++) begin
         verify(0, "t5_pop");
         pop(0);
      end
      verify(0, "t5_empty");
      for (int i = 0; i < 4; i++) send(0, 8'($urandom), 1'b0, 1'b0, ACT_NONE, t0);
      clr_pulse();
      send(0, 8'hE7, 1'b0, 1'b0, ACT_POP, t0);
      verify(0, "t5_push_pop");
      for (int i = 0; i < 4; i++) begin
         pop(0);
         verify(0, "t5_drain");
      end

      // Reset mid-frame discards the partial frame and prior state.
      send(0, 8'h99, 1'b0, 1'b0, ACT_NONE, t0);
      send(0, 8'h55, 1'b0, 1'b1, ACT_NONE, t0);
      d = 8'h77;
      rx_a = 1'b0;
      repeat (CLK_DIV) tick();
      for (int b = 0; b < 3; b++) begin
         rx_a = d[b];
         repeat (CLK_DIV) tick();
      end
      do_reset();
      verify(0, "t6_reset_a");
      verify(1, "t6_reset_p");
      send(0, 8'h3C, 1'b0, 1'b0, ACT_NONE, t0);
      verify(0, "t6_next");

      // Randomized traffic on both instances.
      for (int i = 0; i < 40; i++) begin
         dut = int'($urandom_range(0, 1));
         d   = 8'($urandom);
         bs  = ($urandom_range(0, 7) == 0);
         bp  = (dut == 1) && ($urandom_range(0, 3) == 0);
         send(dut, d, bp, bs, ACT_NONE, t0);
         verify(dut, "rnd_rx");
         if ($urandom_range(0, 2) == 0) begin
            clr_pulse();
            verify(dut, "rnd_clr");
         end
         npop = int'($urandom_range(0, 2));
         for (int k = 0; k < npop; k++) begin
            pop(dut);
            verify(dut, "rnd_pop");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
